skew_feeder: RTL and testbench

- Edge feeder for the systolic MAC array.
- Accepts one N-lane operand vector per cycle over a valid/ready handshake.
- Emits the vector diagonally skewed: lane i is delayed i+1 cycles, so operands meet the PEs on the correct wavefront.
- Tracks tile boundaries, drains the skew pipeline after the last vector, and flags first elements so PEs can clear their accumulators.

---
 rtl/systolic_pkg.sv | 13 +
 rtl/skew_lane.sv | 30 +++
 rtl/skew_feeder.sv | 93 +++++++++
 tb/tb_skew_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array and its edge feeders.
package systolic_pkg;

  localparam int LANES_DEF = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_lane.sv
// One feeder lane: an enabled shift chain of STAGES registers carrying {first, valid, data}.
module skew_lane #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_first,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_first
);

  logic [STAGES-1:0][WIDTH+1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (en) begin
      chain[0] <= {in_first, in_valid, in_data};
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  assign {out_first, out_valid, out_data} = chain[STAGES-1];

endmodule

// File: rtl/skew_feeder.sv
// Array edge feeder: accepts one vector per cycle and emits it diagonally skewed,
// lane i delayed i+1 cycles, with tile tracking and a drain phase after the last vector.
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   array_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES-1:0]       out_first,
  output logic                   tile_done,
  output logic                   busy
);

  localparam int CW = $clog2(LANES);

  feeder_state_e               state, state_nxt;
  logic [CW-1:0]               drain_cnt, cnt_nxt;
  logic                        accept;
  logic [LANES-1:0][WIDTH-1:0] lane_in;
  logic                        first_in;

  assign in_ready = array_en && (state != DRAIN);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  // Unaccepted cycles inject zeroed bubbles so holes stay clean downstream.
  assign lane_in  = accept ? in_data : '0;
  assign first_in = accept && (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = drain_cnt;
    tile_done = 1'b0;
    if (array_en) begin
      case (state)
        IDLE, STREAM: begin
          if (accept && in_last) begin
            state_nxt = DRAIN;
            cnt_nxt   = CW'(LANES - 1);
          end else if (accept) begin
            state_nxt = STREAM;
          end
        end
        DRAIN: begin
          // Count reaches zero exactly when the last vector exits lane LANES-1.
          if (drain_cnt == '0) begin
            tile_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = drain_cnt - CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= cnt_nxt;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    skew_lane #(
      .STAGES(gi + 1),
      .WIDTH (WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (array_en),
      .in_data  (lane_in[gi]),
      .in_valid (accept),
      .in_first (first_in),
      .out_data (out_data[gi*WIDTH +: WIDTH]),
      .out_valid(out_valid[gi]),
      .out_first(out_first[gi])
    );
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: history-based reference model checked every cycle, plus directed pins.
module tb_skew_feeder;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int VW    = LANES * WIDTH;
  localparam int HN    = 4096;

  logic             clk = 1'b0;
  logic             rst_n, array_en, in_valid, in_last;
  logic [VW-1:0]    in_data;
  logic             in_ready, tile_done, busy;
  logic [VW-1:0]    out_data;
  logic [LANES-1:0] out_valid, out_first;

  skew_feeder #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .array_en(array_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_first(out_first),
    .tile_done(tile_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per advance-cycle record of what entered stage 0.
  logic [VW-1:0] hist_d [HN];
  bit            hist_v [HN];
  bit            hist_f [HN];
  int            enc = 0;
  bit            open = 0, have_last = 0, armed = 0;
  int            last_k = 0;

  // Observed outputs captured at the most recent negedge.
  logic [VW-1:0]    obs_data;
  logic [LANES-1:0] obs_valid, obs_first;
  logic             obs_done, obs_ready, obs_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [VW-1:0] d, input bit l, input bit en, input bit rn);
    logic [VW-1:0]    ed;
    logic [LANES-1:0] ev, ef;
    bit               draining, e_ready, e_busy, e_done, acc;
    int               k;
    in_valid = v; in_data = d; in_last = l; array_en = en; rst_n = rn;
    @(negedge clk);
    obs_data = out_data; obs_valid = out_valid; obs_first = out_first;
    obs_done = tile_done; obs_ready = in_ready; obs_busy = busy;
    ed = '0; ev = '0; ef = '0;
    for (int i = 0; i < LANES; i++) begin
      k = enc - i - 1;
      if (k >= 0) begin
        ed[i*WIDTH +: WIDTH] = hist_d[k][i*WIDTH +: WIDTH];
        ev[i] = hist_v[k];
        ef[i] = hist_f[k];
      end
    end
    draining = have_last && (enc > last_k) && (enc <= last_k + LANES);
    e_ready  = en && !draining;
    e_busy   = open || draining;
    e_done   = draining && (enc == last_k + LANES) && en;
    if (armed) begin
      chk("out_data", obs_data, ed);
      chk("out_valid", obs_valid, ev);
      chk("out_first", obs_first, ef);
      chk("tile_done", obs_done, e_done);
      chk("in_ready", obs_ready, e_ready);
      chk("busy", obs_busy, e_busy);
    end
    if (en && enc < HN) begin
      acc = v && e_ready;
      hist_d[enc] = acc ? d : '0;
      hist_v[enc] = acc;
      hist_f[enc] = acc && !open;
      if (acc && l) begin
        open = 0; have_last = 1; last_k = enc;
      end else if (acc) begin
        open = 1;
      end
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      enc = 0; open = 0; have_last = 0; armed = 1;
    end else if (en) begin
      enc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 1, 1);
  endtask

  // Three-vector tile with optional stalls mid-stream and mid-drain.
  task automatic tile3(input int stall_s, input int stall_d, input string nm);
    int n, done_at;
    n = 0; done_at = -1;
    step(1, 32'h04030201, 0, 1, 1); n++;
    step(1, 32'h14131211, 0, 1, 1); n++;
    chk({nm, ".lane0_first_data"}, obs_data[7:0], 8'h01);
    chk({nm, ".first_walk"}, obs_first, 4'b0001);
    for (int i = 0; i < stall_s; i++) begin step(1, 32'hDEADBEEF, 1, 0, 1); n++; end
    step(1, 32'h24232221, 1, 1, 1); n++;
    step(1, 32'h99999999, 0, 1, 1); n++;
    chk({nm, ".ready_in_drain"}, obs_ready, 1'b0);
    for (int i = 0; i < stall_d; i++) begin step(1, 32'hDEADBEEF, 0, 0, 1); n++; end
    for (int i = 0; i < 30 && done_at < 0; i++) begin
      step(0, '0, 0, 1, 1);
      if (obs_done) begin
        done_at = n;
        chk({nm, ".done_lane3"}, obs_data[31:24], 8'h24);
        chk({nm, ".done_valid3"}, obs_valid[3], 1'b1);
      end
      n++;
    end
    chk({nm, ".done_cycle"}, done_at, 6 + stall_s + stall_d);
    step(0, '0, 0, 1, 1);
    chk({nm, ".ready_after"}, obs_ready, 1'b1);
    chk({nm, ".busy_after"}, obs_busy, 1'b0);
  endtask

  initial begin
    int done_at;
    rst_n = 0; array_en = 1; in_valid = 1; in_last = 0; in_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1, 32'hFFFFFFFF, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    chk("reset.ready", obs_ready, 1'b1);
    chk("reset.valid", obs_valid, 4'b0000);
    chk("reset.first", obs_first, 4'b0000);
    chk("reset.done", obs_done, 1'b0);
    chk("reset.busy", obs_busy, 1'b0);

    tile3(0, 0, "tile");
    tile3(5, 5, "stall");

    // Single-vector tile goes straight to DRAIN.
    step(1, 32'hDDCCBBAA, 1, 1, 1);
    step(0, '0, 0, 1, 1);
    chk("single.busy", obs_busy, 1'b1);
    chk("single.ready", obs_ready, 1'b0);
    chk("single.lane0", obs_data[7:0], 8'hAA);
    done_at = -1;
    for (int i = 2; i < 20 && done_at < 0; i++) begin
      step(0, '0, 0, 1, 1);
      if (obs_done) begin
        done_at = i;
        chk("single.lane3", obs_data[31:24], 8'hDD);
        chk("single.first3", obs_first, 4'b1000);
      end
    end
    chk("single.done_cycle", done_at, 4);
    idle(1);

    // Bubble gap of two cycles inside a tile.
    step(1, 32'h31323334, 0, 1, 1);
    idle(2);
    step(1, 32'h41424344, 1, 1, 1);
    idle(7);

    // Reset one cycle before the expected tile_done.
    step(1, 32'h04030201, 0, 1, 1);
    step(1, 32'h14131211, 0, 1, 1);
    step(1, 32'h24232221, 1, 1, 1);
    idle(2);
    step(0, '0, 0, 1, 0);
    chk("rstdrain.no_done", obs_done, 1'b0);
    step(0, '0, 0, 1, 1);
    chk("rstdrain.done_after", obs_done, 1'b0);
    chk("rstdrain.valid", obs_valid, 4'b0000);
    chk("rstdrain.busy", obs_busy, 1'b0);
    tile3(0, 0, "after_rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, VW'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 199) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
